// File: rtl/top.sv
// ROM-sum controller: on start1, sums WORDS consecutive entries of a fixed 16-entry ROM
// beginning at start_address, then presents the sum on out with a one-cycle finish strobe.
module top #(
    parameter int unsigned WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start1,
    input  logic [3:0]  start_address,
    output logic        finish,
    output logic [15:0] out
);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] out_q, out_d;
    logic        finish_q, finish_d;
    logic [15:0] rom_data;

    // mem[i] = i*i + 1
    always_comb begin
        rom_data = 16'd0;
        unique case (ptr_q)
            4'd0:  rom_data = 16'd1;
            4'd1:  rom_data = 16'd2;
            4'd2:  rom_data = 16'd5;
            4'd3:  rom_data = 16'd10;
            4'd4:  rom_data = 16'd17;
            4'd5:  rom_data = 16'd26;
            4'd6:  rom_data = 16'd37;
            4'd7:  rom_data = 16'd50;
            4'd8:  rom_data = 16'd65;
            4'd9:  rom_data = 16'd82;
            4'd10: rom_data = 16'd101;
            4'd11: rom_data = 16'd122;
            4'd12: rom_data = 16'd145;
            4'd13: rom_data = 16'd170;
            4'd14: rom_data = 16'd197;
            4'd15: rom_data = 16'd226;
            default: rom_data = 16'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        out_d    = out_q;
        finish_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start1) begin
                    ptr_d   = start_address;
                    acc_d   = 16'd0;
                    cnt_d   = 5'd0;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                acc_d = acc_q + rom_data;
                ptr_d = ptr_q + 4'd1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(WORDS - 1)) begin
                    out_d    = acc_q + rom_data;
                    finish_d = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            ptr_q    <= 4'd0;
            cnt_q    <= 5'd0;
            acc_q    <= 16'd0;
            out_q    <= 16'd0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            finish_q <= finish_d;
        end
    end

    assign finish = finish_q;
    assign out    = out_q;

endmodule

// File: tb/tb_top.sv
// Directed bench for top: ROM-window sums, wrap, ignored starts, mid-run reset, back-to-back runs.
module tb_top;

    localparam int unsigned WORDS = 4;

    logic        clk;
    logic        rst;
    logic        start1;
    logic [3:0]  start_address;
    logic        finish;
    logic [15:0] out;

    int total = 0;
    int bad   = 0;

    top #(.WORDS(WORDS)) dut (
        .clk           (clk),
        .rst           (rst),
        .start1        (start1),
        .start_address (start_address),
        .finish        (finish),
        .out           (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then expect finish only on the WORDS-th edge after it.
    task automatic run(input string tag, input logic [3:0] addr, input logic [15:0] prev,
                       input logic [15:0] exp);
        start1        = 1'b1;
        start_address = addr;
        step();
        start1 = 1'b0;
        for (int i = 1; i <= int'(WORDS); i++) begin
            step();
            check({tag, "_finish"}, 16'(finish), (i == int'(WORDS)) ? 16'd1 : 16'd0);
            check({tag, "_out"}, out, (i == int'(WORDS)) ? exp : prev);
        end
        step();
        check({tag, "_finish_drop"}, 16'(finish), 16'd0);
        check({tag, "_hold"}, out, exp);
    endtask

    initial begin
        rst           = 1'b0;
        start1        = 1'b0;
        start_address = 4'd0;

        // Reset and idle behaviour
        step();
        step();
        check("reset_out", out, 16'd0);
        check("reset_finish", 16'(finish), 16'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_finish", 16'(finish), 16'd0);
            check("idle_out", out, 16'd0);
        end

        // 2+5+10+17
        run("sum_a1", 4'd1, 16'd0, 16'd34);
        // 197+226+1+2 with pointer wrap
        run("sum_wrap", 4'd14, 16'd34, 16'd426);

        // Start pulsed during ACC must be ignored: 5+10+17+26
        start1        = 1'b1;
        start_address = 4'd2;
        step();
        start1 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 2) begin
                start1        = 1'b1;
                start_address = 4'd0;
            end else begin
                start1 = 1'b0;
            end
            step();
            check("ignore_finish", 16'(finish), (i == int'(WORDS)) ? 16'd1 : 16'd0);
            check("ignore_out", out, (i >= int'(WORDS)) ? 16'd58 : 16'd426);
        end
        start1 = 1'b0;

        // Reset mid-run aborts and clears out
        start1        = 1'b1;
        start_address = 4'd3;
        step();
        start1 = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("midrst_out", out, 16'd0);
        check("midrst_finish", 16'(finish), 16'd0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("postrst_finish", 16'(finish), 16'd0);
            check("postrst_out", out, 16'd0);
        end
        // 1+2+5+10
        run("sum_a0", 4'd0, 16'd0, 16'd18);

        // start1 held high: finish every WORDS+2 edges, never on consecutive edges
        start1        = 1'b1;
        start_address = 4'd1;
        step();
        for (int i = 1; i <= 18; i++) begin
            step();
            check("held_finish", 16'(finish),
                  ((i % int'(WORDS + 2)) == int'(WORDS)) ? 16'd1 : 16'd0);
            check("held_out", out, (i >= int'(WORDS)) ? 16'd34 : 16'd18);
        end
        start1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
